// File: rtl/verilog_behavioral_pkg.sv
// Shared state encoding for the two-input Mealy FSM (y1y2 order).
// Both the behavioral and the gate-level models use these constants.
package verilog_behavioral_pkg;

  typedef enum logic [1:0] {
    ST_A = 2'b00,
    ST_B = 2'b10,
    ST_C = 2'b11,
    ST_D = 2'b01
  } state_t;

endpackage

// File: rtl/verilog_behavioral_dff.sv
// Single-bit D flip-flop with asynchronous active-high reset to 0.
// Storage element for the gate-level twin of the FSM.
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/verilog_structural.sv
// Gate-level twin of verilog_behavioral: sum-of-products next-state and output
// equations over y1y2 and X1X2, with two async-reset flops holding the state.
module verilog_structural (
  input  logic clk,
  input  logic rst,
  input  logic X1,
  input  logic X2,
  output logic Z1,
  output logic Z2
);

  wire y1, y2;
  wire ny1, ny2, nx1, nx2;
  wire t0, t1, t2, t3, t4, t5, t6, t7;
  wire x1_nx2, n_x1_nx2;
  wire d1, d2;
  wire z1_w, z2_w;

  not g_ny1 (ny1, y1);
  not g_ny2 (ny2, y2);
  not g_nx1 (nx1, X1);
  not g_nx2 (nx2, X2);

  // Y1+ terms; t1 is shared with Y2+ (the B --01--> C transition).
  and g_t0 (t0, ny1, ny2, X1, X2);
  and g_t1 (t1, y1, ny2, nx1, X2);
  and g_t2 (t2, y1, ny2, X1, X2);
  and g_x1nx2 (x1_nx2, X1, nx2);
  not g_nx1nx2 (n_x1_nx2, x1_nx2);
  and g_t3 (t3, y1, y2, n_x1_nx2);
  or  g_d1 (d1, t0, t1, t2, t3);

  and g_t4 (t4, y1, y2);
  and g_t5 (t5, ny1, y2, X1);
  or  g_d2 (d2, t1, t4, t5);

  and g_t6 (t6, y1, ny2);
  and g_t7 (t7, ny1, y2, X1, nx2);
  buf g_z1 (z1_w, y1);
  or  g_z2 (z2_w, t6, t7);

  assign Z1 = z1_w;
  assign Z2 = z2_w;

  dff_ar u_ff_y1 (.clk(clk), .rst(rst), .d(d1), .q(y1));
  dff_ar u_ff_y2 (.clk(clk), .rst(rst), .d(d2), .q(y2));

endmodule

// File: rtl/verilog_behavioral.sv
// Two-input, two-output Mealy FSM (states A/B/C/D encoded y1y2).
// Outputs are combinational from the registered state and the live inputs.
module verilog_behavioral
  import verilog_behavioral_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic X1,
  input  logic X2,
  output logic Z1,
  output logic Z2
);

  state_t     state_reg;
  state_t     state_next;
  logic [1:0] x;

  assign x = {X1, X2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_A;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    Z1         = 1'b0;
    Z2         = 1'b0;
    case (state_reg)
      ST_A: begin
        if (x == 2'b11) state_next = ST_B;
      end
      ST_B: begin
        Z1 = 1'b1;
        Z2 = 1'b1;
        case (x)
          2'b01:   state_next = ST_C;
          2'b11:   state_next = ST_B;
          default: state_next = ST_A;
        endcase
      end
      ST_C: begin
        Z1 = 1'b1;
        if (x == 2'b10) state_next = ST_D;
      end
      ST_D: begin
        // Only Mealy output: asserted while D sees X=10.
        Z2 = (x == 2'b10);
        if (!X1) state_next = ST_A;
      end
      default: state_next = ST_A;
    endcase
  end

endmodule

// File: tb/tb_verilog_behavioral.sv
// Bench for verilog_behavioral: checks it and the gate-level twin against an
// independent table model, and against each other, with a scoreboard queue.
module tb_verilog_behavioral;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x1  = 1'b0;
  logic x2  = 1'b0;
  logic zb1, zb2, zs1, zs2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_q[$];
  logic [1:0] model_s = 2'b00;  // y1y2

  verilog_behavioral dut_b (.clk(clk), .rst(rst), .X1(x1), .X2(x2), .Z1(zb1), .Z2(zb2));
  verilog_structural dut_s (.clk(clk), .rst(rst), .X1(x1), .X2(x2), .Z1(zs1), .Z2(zs2));

  always #5 clk = ~clk;

  // Next-state table indexed [state y1y2][input X1X2]
  function automatic logic [1:0] model_next(input logic [1:0] s, input logic [1:0] x);
    logic [1:0] tbl [4][4];
    // state 00 = A
    tbl[0] = '{2'b00, 2'b00, 2'b00, 2'b10};
    // state 01 = D
    tbl[1] = '{2'b00, 2'b00, 2'b01, 2'b01};
    // state 10 = B
    tbl[2] = '{2'b00, 2'b11, 2'b00, 2'b10};
    // state 11 = C
    tbl[3] = '{2'b11, 2'b11, 2'b01, 2'b11};
    return tbl[s][x];
  endfunction

  function automatic logic [1:0] model_z(input logic [1:0] s, input logic [1:0] x);
    if (s == 2'b00) return 2'b00;
    if (s == 2'b10) return 2'b11;
    if (s == 2'b11) return 2'b10;
    return (x == 2'b10) ? 2'b01 : 2'b00;
  endfunction

  // Drive X at the falling edge, push the expected post-edge Z, then step past the edge.
  task automatic apply(input logic [1:0] x);
    @(negedge clk);
    {x1, x2} = x;
    if (rst) model_s = 2'b00;
    else     model_s = model_next(model_s, x);
    exp_q.push_back(model_z(model_s, x));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] exp;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({zb1, zb2} !== 2'b00 || {zs1, zs2} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_initial beh=%b str=%b exp=00", {zb1, zb2}, {zs1, zs2});
    end
    // X=11 across an edge while in reset must not reach B.
    apply(2'b11);
    exp = exp_q.pop_front();
    n_tests++;
    if ({zb1, zb2} !== exp || {zs1, zs2} !== exp) begin
      n_fail++;
      $display("FAIL reset_hold beh=%b str=%b exp=%b", {zb1, zb2}, {zs1, zs2}, exp);
    end
    @(negedge clk);
    rst = 1'b0;
    apply(2'b00);
    exp = exp_q.pop_front();
    n_tests++;
    if ({zb1, zb2} !== exp || {zs1, zs2} !== exp) begin
      n_fail++;
      $display("FAIL reset_release beh=%b str=%b exp=%b", {zb1, zb2}, {zs1, zs2}, exp);
    end
  endtask

  task automatic test_walk();
    logic [1:0] seq [8] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] req [8] = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      apply(seq[i]);
      exp = exp_q.pop_front();
      n_tests++;
      if ({zb1, zb2} !== exp || {zb1, zb2} !== req[i]) begin
        n_fail++;
        $display("FAIL walk_beh step=%0d x=%b z=%b model=%b table=%b", i, seq[i], {zb1, zb2}, exp, req[i]);
      end
      n_tests++;
      if ({zs1, zs2} !== exp) begin
        n_fail++;
        $display("FAIL walk_str step=%0d x=%b z=%b exp=%b", i, seq[i], {zs1, zs2}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp;
    apply(2'b11);
    void'(exp_q.pop_front());
    apply(2'b01);
    exp = exp_q.pop_front();
    n_tests++;
    if ({zb1, zb2} !== 2'b10 || {zs1, zs2} !== 2'b10 || exp !== 2'b10) begin
      n_fail++;
      $display("FAIL async_pre_c beh=%b str=%b exp=10", {zb1, zb2}, {zs1, zs2});
    end
    // Assert reset mid-low-phase: no clock edge involved.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_s = 2'b00;
    n_tests++;
    if ({zb1, zb2} !== 2'b00 || {zs1, zs2} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset beh=%b str=%b exp=00", {zb1, zb2}, {zs1, zs2});
    end
    @(negedge clk);
    rst = 1'b0;
    apply(2'b11);
    exp = exp_q.pop_front();
    n_tests++;
    if ({zb1, zb2} !== exp || {zs1, zs2} !== exp) begin
      n_fail++;
      $display("FAIL async_after beh=%b str=%b exp=%b", {zb1, zb2}, {zs1, zs2}, exp);
    end
  endtask

  task automatic test_random();
    logic [1:0] exp;
    logic [1:0] x;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      x = 2'($urandom_range(0, 3));
      apply(x);
      exp = exp_q.pop_front();
      n_tests++;
      if ({zb1, zb2} !== exp || {zs1, zs2} !== {zb1, zb2}) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc=%0d x=%b beh=%b str=%b exp=%b", i, x, {zb1, zb2}, {zs1, zs2}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
